// File: rtl/reg_scoreboard_if.sv
// Decode-side handshake bundle between register control and the hazard scoreboard.
// The master drives the decode/writeback view; the slave returns stall/issue and status.
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 32
) ();
    logic                id_valid;
    logic [4:0]          rs1_addr;
    logic                rs1_rden;
    logic [4:0]          rs2_addr;
    logic                rs2_rden;
    logic [4:0]          rd_addr;
    logic                rd_wren;
    logic                ex_ready;
    logic                wb_valid;
    logic [4:0]          wb_rd_addr;
    logic                flush;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:0] pending;
    logic                sb_err;

    modport master (
        output id_valid, rs1_addr, rs1_rden, rs2_addr, rs2_rden, rd_addr, rd_wren,
               ex_ready, wb_valid, wb_rd_addr, flush,
        input  stall, issue, pending, sb_err
    );

    modport slave (
        input  id_valid, rs1_addr, rs1_rden, rs2_addr, rs2_rden, rd_addr, rd_wren,
               ex_ready, wb_valid, wb_rd_addr, flush,
        output stall, issue, pending, sb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register in-flight write counters that
// stall issue on RAW hazards or counter saturation, released by writeback or flush.
module reg_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             sb_err_q, sb_err_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             wb_rel_rs1, wb_rel_rs2;
    logic             raw1, raw2, sat;
    logic             stall_c, issue_c;
    logic             inc, dec, wb_err;
    logic [NUM_REGS-1:0] pending_c;

    always_comb begin
        cnt_rs1 = cnt_q[sb.rs1_addr];
        cnt_rs2 = cnt_q[sb.rs2_addr];
        cnt_rd  = cnt_q[sb.rd_addr];
        cnt_wb  = cnt_q[sb.wb_rd_addr];

        // A retiring last write can release the reader in the same cycle via write-through.
        wb_rel_rs1 = (WB_BYPASS != 0) && sb.wb_valid && (sb.wb_rd_addr == sb.rs1_addr)
                     && (cnt_rs1 == CNT_ONE);
        wb_rel_rs2 = (WB_BYPASS != 0) && sb.wb_valid && (sb.wb_rd_addr == sb.rs2_addr)
                     && (cnt_rs2 == CNT_ONE);

        raw1 = sb.rs1_rden && (sb.rs1_addr != 5'd0) && (cnt_rs1 != '0) && !wb_rel_rs1;
        raw2 = sb.rs2_rden && (sb.rs2_addr != 5'd0) && (cnt_rs2 != '0) && !wb_rel_rs2;
        sat  = sb.rd_wren && (sb.rd_addr != 5'd0) && (cnt_rd == CNT_MAX)
               && !(sb.wb_valid && (sb.wb_rd_addr == sb.rd_addr));

        stall_c = !rst && sb.id_valid && !sb.flush && (raw1 || raw2 || sat);
        issue_c = !rst && sb.id_valid && !sb.flush && !stall_c && sb.ex_ready;

        inc    = issue_c && sb.rd_wren && (sb.rd_addr != 5'd0);
        dec    = sb.wb_valid && (sb.wb_rd_addr != 5'd0) && (cnt_wb != '0);
        wb_err = sb.wb_valid && (sb.wb_rd_addr != 5'd0) && (cnt_wb == '0);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sb.flush) begin
                cnt_d[i] = '0;
            end else begin
                // Simultaneous inc and dec on one register cancel out.
                if (inc && (sb.rd_addr == 5'(i)) && !(dec && (sb.wb_rd_addr == 5'(i)))) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else if (dec && (sb.wb_rd_addr == 5'(i)) && !(inc && (sb.rd_addr == 5'(i)))) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
        sb_err_d = sb_err_q || (!sb.flush && wb_err);
    end

    always_comb begin
        pending_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_c[i] = (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb.stall   = stall_c;
    assign sb.issue   = issue_c;
    assign sb.pending = pending_c;
    assign sb.sb_err  = sb_err_q;
endmodule
